result_output_stage: RTL and testbench

RESULT_OUTPUT_STAGE -- requirements
Module: result_output_stage

---
 rtl/result_output_stage_if.sv | 33 +++
 rtl/result_output_stage.sv | 132 +++++++++++++
 tb/tb_result_output_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_output_stage_if.sv
// Bundle of request, FIFO and status signals for the result output stage.
// The master side issues record requests and owns the FIFO free counts;
// the slave side is the output stage itself.
interface result_output_stage_if #(
    parameter int word_size = 16,
    parameter int cnt_size  = 16
);
    logic                     en_wr_output_fifo;
    logic [2*word_size-1:0]   result;
    logic [2*word_size-1:0]   status;
    logic [word_size-1:0]     free_result;
    logic [word_size-1:0]     free_status;
    logic                     wr_result;
    logic                     wr_status;
    logic [word_size-1:0]     data_result;
    logic [word_size-1:0]     data_status;
    logic                     ready;
    logic                     done;
    logic                     drop_err;
    logic [cnt_size-1:0]      rec_count;

    modport master (
        output en_wr_output_fifo, result, status, free_result, free_status,
        input  wr_result, wr_status, data_result, data_status,
        input  ready, done, drop_err, rec_count
    );

    modport slave (
        input  en_wr_output_fifo, result, status, free_result, free_status,
        output wr_result, wr_status, data_result, data_status,
        output ready, done, drop_err, rec_count
    );
endinterface

// File: rtl/result_output_stage.sv
// Result output stage: captures a two-word result/status record on a request
// pulse, waits until both FIFOs can take two tokens, writes the low halves then
// the high halves on consecutive cycles, and pulses done while counting records.
module result_output_stage #(
    parameter int word_size = 16,
    parameter int cnt_size  = 16
) (
    input  logic               clk,
    input  logic               rst,
    result_output_stage_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [word_size-1:0] min_free = word_size'(2);

    state_t                 state_reg;
    state_t                 state_next;
    logic [2*word_size-1:0] res_reg;
    logic [2*word_size-1:0] sta_reg;
    logic                   drop_reg;
    logic [cnt_size-1:0]    cnt_reg;
    logic                   accept;
    logic                   space_ok;

    // Captured records split into halves: index 0 is written first, index 1 second.
    logic [word_size-1:0]   res_half [2];
    logic [word_size-1:0]   sta_half [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign res_half[gi] = res_reg[gi*word_size +: word_size];
            assign sta_half[gi] = sta_reg[gi*word_size +: word_size];
        end
    endgenerate

    assign accept   = (state_reg == IDLE) && bus.en_wr_output_fifo;
    assign space_ok = (bus.free_result >= min_free) && (bus.free_status >= min_free);

    // State register; reset drops any record in flight so no further write happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and all per-state outputs; outputs are zero unless a state drives them.
    always_comb begin
        state_next      = state_reg;
        bus.ready       = 1'b0;
        bus.done        = 1'b0;
        bus.wr_result   = 1'b0;
        bus.wr_status   = 1'b0;
        bus.data_result = '0;
        bus.data_status = '0;
        case (state_reg)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.en_wr_output_fifo) begin
                    state_next = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (space_ok) begin
                    state_next = WR_LO;
                end
            end
            WR_LO: begin
                bus.wr_result   = 1'b1;
                bus.wr_status   = 1'b1;
                bus.data_result = res_half[0];
                bus.data_status = sta_half[0];
                state_next      = WR_HI;
            end
            WR_HI: begin
                bus.wr_result   = 1'b1;
                bus.wr_status   = 1'b1;
                bus.data_result = res_half[1];
                bus.data_status = sta_half[1];
                state_next      = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture registers load only on an accepted request, so later input changes are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_reg <= '0;
            sta_reg <= '0;
        end else if (accept) begin
            res_reg <= bus.result;
            sta_reg <= bus.status;
        end
    end

    // Sticky error for any request that arrives while a record is still in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_reg <= 1'b0;
        end else if (bus.en_wr_output_fifo && (state_reg != IDLE)) begin
            drop_reg <= 1'b1;
        end
    end

    // Record counter advances once per completed record and wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (state_reg == DONE) begin
            cnt_reg <= cnt_reg + cnt_size'(1);
        end
    end

    assign bus.drop_err  = drop_reg;
    assign bus.rec_count = cnt_reg;

endmodule

// File: tb/tb_result_output_stage.sv
// Directed bench for result_output_stage: a record-level model (queue of
// expected FIFO words, expected count and error flag) checked every cycle,
// plus literal expectations for the single-record, back-pressure, collision,
// reset, back-to-back and counter-wrap scenarios.
module tb_result_output_stage;
    logic clk;
    logic rst;

    result_output_stage_if #(.word_size(16), .cnt_size(16)) bus ();
    result_output_stage_if #(.word_size(16), .cnt_size(4))  bus4 ();

    result_output_stage #(.word_size(16), .cnt_size(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter copy sees the same traffic to exercise counter wrap.
    result_output_stage #(.word_size(16), .cnt_size(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.en_wr_output_fifo = bus.en_wr_output_fifo;
    assign bus4.result            = bus.result;
    assign bus4.status            = bus.status;
    assign bus4.free_result       = bus.free_result;
    assign bus4.free_status       = bus.free_status;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] s;
    } word_t;

    word_t       exp_q[$];
    word_t       cur_w;
    int          pend;
    logic [15:0] exp_count;
    logic        exp_drop;
    int          checks;
    int          errors;
    int          wr_r_cnt;
    int          wr_s_cnt;
    int          done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the record-level model.
    always @(negedge clk) begin
        chk("rec_count", 32'(bus.rec_count), 32'(exp_count));
        chk("rec_count_wrap", 32'(bus4.rec_count), 32'(exp_count[3:0]));
        chk("drop_err", 32'(bus.drop_err), 32'(exp_drop));
        chk("wr_pair", 32'(bus.wr_result), 32'(bus.wr_status));
        if (bus.wr_result) wr_r_cnt++;
        if (bus.wr_status) wr_s_cnt++;
        if (bus.wr_result || bus.wr_status) begin
            chk("ready_busy", 32'(bus.ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                cur_w = exp_q.pop_front();
                chk("data_result", 32'(bus.data_result), 32'(cur_w.r));
                chk("data_status", 32'(bus.data_status), 32'(cur_w.s));
            end
        end else begin
            chk("idle_data", {bus.data_result, bus.data_status}, 32'd0);
        end
        if (bus.done) begin
            done_cnt++;
            chk("done_words_out", 32'(exp_q.size()), 32'd0);
            if (pend == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                pend--;
                exp_count++;
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        pend      = 0;
        exp_count = '0;
        exp_drop  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Issue one request once the block is ready; inputs are scrambled after capture.
    task automatic send(input logic [31:0] r, input logic [31:0] s);
        int n;
        n = 0;
        @(negedge clk); #2;
        while (!bus.ready && n < 50) begin
            @(negedge clk); #2;
            n++;
        end
        chk("ready_wait", 32'(bus.ready), 32'd1);
        bus.result            = r;
        bus.status            = s;
        bus.en_wr_output_fifo = 1'b1;
        @(posedge clk); #1;
        bus.en_wr_output_fifo = 1'b0;
        bus.result            = ~r;
        bus.status            = ~s;
        exp_q.push_back({r[15:0], s[15:0]});
        exp_q.push_back({r[31:16], s[31:16]});
        pend++;
    endtask

    // Wait for every modelled record to finish, then one more cycle for the count.
    task automatic wait_idle();
        int n;
        n = 0;
        while (pend != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(pend), 32'd0);
        @(negedge clk);
    endtask

    int wr_r0;
    int wr_s0;
    int done0;
    int bp_writes;
    int n_wait;

    initial begin
        checks = 0;
        errors = 0;
        wr_r_cnt = 0;
        wr_s_cnt = 0;
        done_cnt = 0;
        model_clear();
        rst = 1'b0;
        bus.en_wr_output_fifo = 1'b0;
        bus.result      = '0;
        bus.status      = '0;
        bus.free_result = 16'd8;
        bus.free_status = 16'd8;

        // Reset state
        @(negedge clk); #2;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_outputs", {28'd0, bus.wr_result, bus.wr_status, bus.done, bus.drop_err}, 32'd0);
        chk("rst_count", 32'(bus.rec_count), 32'd0);
        @(negedge clk); #2;
        rst = 1'b1;

        // Single record with literal timing
        send(32'h12345678, 32'h0000ABCD);
        @(negedge clk);
        chk("t1_wait_nowrite", 32'(bus.wr_result), 32'd0);
        @(negedge clk);
        chk("t1_lo", {bus.data_result, bus.data_status}, 32'h5678ABCD);
        @(negedge clk);
        chk("t1_hi", {bus.data_result, bus.data_status}, 32'h12340000);
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("t1_count", 32'(bus.rec_count), 32'd1);
        chk("t1_done_low", 32'(bus.done), 32'd0);

        // Back-pressure on the status FIFO
        bus.free_status = 16'd1;
        send(32'hCAFE0001, 32'hBEEF0002);
        bp_writes = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wr_result || bus.wr_status || bus.done) bp_writes++;
        end
        chk("t2_held", 32'(bp_writes), 32'd0);
        #2 bus.free_status = 16'd2;
        wr_r0 = wr_r_cnt;
        wait_idle();
        chk("t2_writes", 32'(wr_r_cnt - wr_r0), 32'd2);
        chk("t2_count", 32'(bus.rec_count), 32'd2);
        chk("t2_drop", 32'(bus.drop_err), 32'd0);
        bus.free_status = 16'd8;

        // Collision: second request during WR_LO is dropped
        send(32'hAAAA5555, 32'h11112222);
        n_wait = 0;
        while (!bus.wr_result && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        chk("t3_reach_wr_lo", 32'(bus.wr_result), 32'd1);
        #2;
        bus.result            = 32'h99998888;
        bus.status            = 32'h77776666;
        bus.en_wr_output_fifo = 1'b1;
        @(posedge clk); #1;
        bus.en_wr_output_fifo = 1'b0;
        exp_drop = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("t3_count", 32'(bus.rec_count), 32'd3);
        chk("t3_drop", 32'(bus.drop_err), 32'd1);

        // Reset during WR_HI aborts the record
        send(32'h0BAD0F00, 32'h0D0E0A0D);
        n_wait = 0;
        while (!bus.wr_result && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        @(negedge clk);
        chk("t4_in_wr_hi", {bus.data_result, bus.data_status}, 32'h0BAD0D0E);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_wr", {30'd0, bus.wr_result, bus.wr_status}, 32'd0);
        chk("t4_rst_data", {bus.data_result, bus.data_status}, 32'd0);
        chk("t4_rst_count", 32'(bus.rec_count), 32'd0);
        chk("t4_rst_drop", 32'(bus.drop_err), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        send(32'h00010002, 32'h00030004);
        wait_idle();
        chk("t4_after", 32'(bus.rec_count), 32'd1);

        // Back-to-back records
        do_reset();
        wr_r0 = wr_r_cnt;
        wr_s0 = wr_s_cnt;
        done0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            send(32'h10001000 + 32'(i), 32'h20002000 + 32'(i * 16));
        end
        wait_idle();
        chk("t5_wr_result", 32'(wr_r_cnt - wr_r0), 32'd6);
        chk("t5_wr_status", 32'(wr_s_cnt - wr_s0), 32'd6);
        chk("t5_done", 32'(done_cnt - done0), 32'd3);
        chk("t5_count", 32'(bus.rec_count), 32'd3);
        chk("t5_drop", 32'(bus.drop_err), 32'd0);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(32'h00FF0000 | 32'(i), 32'hFF000000 | 32'(i * 3));
        end
        wait_idle();
        chk("t6_count16", 32'(bus.rec_count), 32'd17);
        chk("t6_count4", 32'(bus4.rec_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
